// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind a UART receiver: sync hunt, CMD/LEN/payload/CHK collection,
// inter-byte timeout, and a held frame released by valid/ack with an addressable payload buffer.
module uart_rx_frame_ctrl #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int MAX_PAYLOAD   = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_RX_DV,
  input  logic [7:0]                       i_RX_Byte,
  input  logic                             i_Frame_Ack,
  input  logic [$clog2(MAX_PAYLOAD)-1:0]   i_Rd_Addr,
  output logic [7:0]                       o_Rd_Data,
  output logic                             o_Frame_Valid,
  output logic [7:0]                       o_Frame_Cmd,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] o_Frame_Len,
  output logic                             o_Busy,
  output logic                             o_Err_Checksum,
  output logic                             o_Err_Length,
  output logic                             o_Err_Timeout,
  output logic                             o_Err_Overrun
);
  localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0] SYNC = 8'hA5;

  // IDLE: hunt sync | GET_*: collect field | HOLD: frame presented until ack
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_LEN, GET_PAYLOAD, GET_CHK, HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]      r_sum, w_sum_nxt;
  logic [7:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_cmd_sh, w_cmd_sh_nxt;
  logic [7:0]      r_len_sh, w_len_sh_nxt;
  logic [7:0]      r_frame_cmd;
  logic [LW-1:0]   r_frame_len;
  logic            r_err_chk, r_err_len, r_err_to, r_err_ovr;
  logic            w_err_chk, w_err_len, w_err_to, w_err_ovr;
  logic            w_buf_we, w_load;
  logic [7:0]      r_buf [MAX_PAYLOAD];

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_cmd_sh    <= '0;
      r_len_sh    <= '0;
      r_frame_cmd <= '0;
      r_frame_len <= '0;
      r_err_chk   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sum     <= w_sum_nxt;
      r_idx     <= w_idx_nxt;
      r_cmd_sh  <= w_cmd_sh_nxt;
      r_len_sh  <= w_len_sh_nxt;
      r_err_chk <= w_err_chk;
      r_err_len <= w_err_len;
      r_err_to  <= w_err_to;
      r_err_ovr <= w_err_ovr;
      if (w_load) begin
        r_frame_cmd <= r_cmd_sh;
        r_frame_len <= LW'(r_len_sh);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_buf_we) r_buf[r_idx[AW-1:0]] <= i_RX_Byte;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_sum_nxt    = r_sum;
    w_idx_nxt    = r_idx;
    w_cmd_sh_nxt = r_cmd_sh;
    w_len_sh_nxt = r_len_sh;
    w_buf_we     = 1'b0;
    w_load       = 1'b0;
    w_err_chk    = 1'b0;
    w_err_len    = 1'b0;
    w_err_to     = 1'b0;
    w_err_ovr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_RX_DV && i_RX_Byte == SYNC) w_state_nxt = GET_CMD;
      end
      GET_CMD, GET_LEN, GET_PAYLOAD, GET_CHK: begin
        if (!i_RX_DV) begin
          if (r_cnt == CW'(TIMEOUT_CLKS - 1)) begin
            w_err_to    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_state == GET_CMD) begin
          w_cmd_sh_nxt = i_RX_Byte;
          w_sum_nxt    = i_RX_Byte;
          w_state_nxt  = GET_LEN;
        end else if (r_state == GET_LEN) begin
          if (i_RX_Byte > 8'(MAX_PAYLOAD)) begin
            w_err_len   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_len_sh_nxt = i_RX_Byte;
            w_sum_nxt    = r_sum + i_RX_Byte;
            w_idx_nxt    = '0;
            w_state_nxt  = (i_RX_Byte == 8'd0) ? GET_CHK : GET_PAYLOAD;
          end
        end else if (r_state == GET_PAYLOAD) begin
          w_buf_we  = 1'b1;
          w_sum_nxt = r_sum + i_RX_Byte;
          if (r_idx == r_len_sh - 8'd1) w_state_nxt = GET_CHK;
          else                          w_idx_nxt   = r_idx + 8'd1;
        end else begin
          if (i_RX_Byte == r_sum) begin
            w_load      = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_err_chk   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        // Ack frees the frame this cycle, so a coincident byte is judged as an IDLE byte.
        if (i_Frame_Ack)  w_state_nxt = (i_RX_DV && i_RX_Byte == SYNC) ? GET_CMD : IDLE;
        else if (i_RX_DV) w_err_ovr   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_Rd_Data      = (LW'(i_Rd_Addr) < r_frame_len) ? r_buf[i_Rd_Addr] : 8'h00;
  assign o_Frame_Valid  = (r_state == HOLD);
  assign o_Busy         = (r_state != IDLE);
  assign o_Frame_Cmd    = r_frame_cmd;
  assign o_Frame_Len    = r_frame_len;
  assign o_Err_Checksum = r_err_chk;
  assign o_Err_Length   = r_err_len;
  assign o_Err_Timeout  = r_err_to;
  assign o_Err_Overrun  = r_err_ovr;
endmodule
